// File: rtl/difficulty_ramp.sv
// rtl/difficulty_ramp.sv - level/difficulty controller driving the timer cluster period-decrement bus
// Optional kill-driven advance is built only when DIFFICULTY_KILL_BOOST_EN is defined.
module difficulty_ramp #(
  parameter int TICKS_PER_LEVEL = 10,
  parameter int KILLS_PER_LEVEL = 5,
  parameter int DEC_STEP        = 2_000_000,
  parameter int DEC_MAX         = 60_000_000,
  parameter int MAX_LEVEL       = 15,
  parameter int LEVELW          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              game_over,
  input  logic              tick,
  input  logic              kill,
  output logic [30:0]       dec,
  output logic [LEVELW-1:0] level,
  output logic              level_up,
  output logic              running
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  localparam int TCW = $clog2(TICKS_PER_LEVEL + 1);

  state_t            state_q, state_d;
  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [30:0]       dec_d;
  logic [LEVELW-1:0] level_d;
  logic              level_up_d;
  logic              running_d;

  logic              take_start;
  logic              count_en;
  logic              tick_hit;
  logic              kill_hit;
  logic              advance;
  logic [31:0]       dec_sum;
  logic [30:0]       dec_sat;

  // game_over beats a coincident start; inputs in a control cycle are not counted
  assign take_start = start && !game_over;
  assign count_en   = (state_q == S_RUN) && !start && !game_over;
  assign tick_hit   = count_en && tick && (tick_cnt_q == TCW'(TICKS_PER_LEVEL - 1));
  assign advance    = tick_hit || kill_hit;

  assign dec_sum = {1'b0, dec} + 32'(DEC_STEP);
  assign dec_sat = (dec_sum > 32'(DEC_MAX)) ? 31'(DEC_MAX) : dec_sum[30:0];

`ifdef DIFFICULTY_KILL_BOOST_EN
  localparam int KCW = $clog2(KILLS_PER_LEVEL + 1);

  logic [KCW-1:0] kill_cnt_q, kill_cnt_d;

  assign kill_hit = count_en && kill && (kill_cnt_q == KCW'(KILLS_PER_LEVEL - 1));

  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (take_start) begin
      kill_cnt_d = '0;
    end else if (count_en && kill) begin
      kill_cnt_d = kill_hit ? '0 : kill_cnt_q + KCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      kill_cnt_q <= '0;
    end else begin
      kill_cnt_q <= kill_cnt_d;
    end
  end
`else
  logic kill_unused;

  assign kill_hit    = 1'b0;
  assign kill_unused = kill | (KILLS_PER_LEVEL < 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (take_start) state_d = S_RUN;
      S_RUN:    if (game_over)  state_d = S_FROZEN;
      S_FROZEN: if (take_start) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    level_d    = level;
    dec_d      = dec;
    level_up_d = 1'b0;
    running_d  = (state_d == S_RUN);
    if (take_start) begin
      tick_cnt_d = '0;
      level_d    = '0;
      dec_d      = '0;
    end else if (count_en) begin
      if (tick) begin
        tick_cnt_d = tick_hit ? '0 : tick_cnt_q + TCW'(1);
      end
      // at the ceiling the counters still wrap but nothing else moves
      if (advance && (level < LEVELW'(MAX_LEVEL))) begin
        level_d    = level + LEVELW'(1);
        dec_d      = dec_sat;
        level_up_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      level      <= '0;
      dec        <= '0;
      level_up   <= 1'b0;
      running    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      level      <= level_d;
      dec        <= dec_d;
      level_up   <= level_up_d;
      running    <= running_d;
    end
  end

endmodule

// File: tb/tb_difficulty_ramp.sv
// tb/tb_difficulty_ramp.sv - vector table plus scoreboard bench for difficulty_ramp
module tb_difficulty_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        game_over;
  logic        tick;
  logic        kill;
  logic [30:0] dec;
  logic [1:0]  level;
  logic        level_up;
  logic        running;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic s;
    logic g;
    logic t;
    logic k;
    int   lvl;
    int   dv;
    logic lu;
    logic run;
    string tag;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  difficulty_ramp #(
    .TICKS_PER_LEVEL(4),
    .KILLS_PER_LEVEL(2),
    .DEC_STEP(1000),
    .DEC_MAX(2500),
    .MAX_LEVEL(3),
    .LEVELW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .game_over(game_over),
    .tick(tick),
    .kill(kill),
    .dec(dec),
    .level(level),
    .level_up(level_up),
    .running(running)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      total++;
      if (dec > 31'd2500) begin
        bad++;
        $display("FAIL dec_ceiling: dec=%0d limit=2500", dec);
      end
    end
  end

  function automatic void add(input logic s, input logic g, input logic t, input logic k,
                              input int lvl, input int dv, input logic lu, input logic run,
                              input string tag);
    vec_t v;
    v.s = s; v.g = g; v.t = t; v.k = k;
    v.lvl = lvl; v.dv = dv; v.lu = lu; v.run = run; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int lvl, input int dv, input logic lu, input logic run);
    check({tag, ".level"},    int'(level),    lvl);
    check({tag, ".dec"},      int'(dec),      dv);
    check({tag, ".level_up"}, int'(level_up), int'(lu));
    check({tag, ".running"},  int'(running),  int'(run));
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    start = v.s; game_over = v.g; tick = v.t; kill = v.k;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got=0 want=1");
    end else begin
      e = exp_q.pop_front();
      check_outs(e.tag, e.lvl, e.dv, e.lu, e.run);
    end
    start = 1'b0; game_over = 1'b0; tick = 1'b0; kill = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic g, input logic t, input logic k,
                       input int lvl, input int dv, input logic lu, input logic run,
                       input string tag);
    vec_t v;
    v.s = s; v.g = g; v.t = t; v.k = k;
    v.lvl = lvl; v.dv = dv; v.lu = lu; v.run = run; v.tag = tag;
    step(v);
  endtask

  initial begin
    // idle ticks are ignored
    add(0,0,1,0, 0,0,0,0, "idle_tick0");
    add(0,0,1,0, 0,0,0,0, "idle_tick1");
    // ramp to the ceiling with saturation
    add(1,0,0,0, 0,0,0,1, "t1_start");
    repeat (3) add(0,0,1,0, 0,0,0,1, "t1_tick");
    add(0,0,1,0, 1,1000,1,1, "t1_adv1");
    add(0,0,0,0, 1,1000,0,1, "t1_lu_one_cycle");
    repeat (3) add(0,0,1,0, 1,1000,0,1, "t1_tick_l1");
    add(0,0,1,0, 2,2000,1,1, "t1_adv2");
    repeat (3) add(0,0,1,0, 2,2000,0,1, "t1_tick_l2");
    add(0,0,1,0, 3,2500,1,1, "t1_adv3_sat");
    repeat (4) add(0,0,1,0, 3,2500,0,1, "t2_at_max");
    // freeze and restart
    add(1,0,0,0, 0,0,0,1, "t3_start");
    repeat (3) add(0,0,1,0, 0,0,0,1, "t3_tick");
    add(0,0,1,0, 1,1000,1,1, "t3_adv1");
    add(0,1,0,0, 1,1000,0,0, "t3_over");
    repeat (8) add(0,0,1,0, 1,1000,0,0, "t3_frozen_tick");
    add(1,0,0,0, 0,0,0,1, "t3_restart");
    // start+game_over together, and ticks coincident with control pulses
    repeat (3) add(0,0,1,0, 0,0,0,1, "t4_tick");
    add(0,0,1,0, 1,1000,1,1, "t4_adv1");
    add(1,1,0,0, 1,1000,0,0, "t4_both");
    add(0,0,1,0, 1,1000,0,0, "t4_frozen_tick");
    add(1,0,1,0, 0,0,0,1, "t4_start_tick");
    repeat (3) add(0,0,1,0, 0,0,0,1, "t4_tick_after");
    add(0,0,1,0, 1,1000,1,1, "t4_adv_after");
    add(0,1,1,0, 1,1000,0,0, "t4_over_tick");
    add(1,0,0,0, 0,0,0,1, "t5_start");
`ifdef DIFFICULTY_KILL_BOOST_EN
    add(0,0,0,1, 0,0,0,1, "t5_kill1");
    repeat (3) add(0,0,1,0, 0,0,0,1, "t5_tick");
    add(0,0,1,1, 1,1000,1,1, "t5_tick_kill");
    add(0,0,0,1, 1,1000,0,1, "t5_kill_wrapped");
    add(0,0,0,1, 2,2000,1,1, "t5_kill_adv");
    repeat (3) add(0,0,1,0, 2,2000,0,1, "t5_tick_wrapped");
    add(0,0,1,0, 3,2500,1,1, "t5_tick_adv");
`else
    repeat (10) add(0,0,0,1, 0,0,0,1, "t5_kill_ignored");
    repeat (3) add(0,0,1,0, 0,0,0,1, "t5_tick");
    add(0,0,1,0, 1,1000,1,1, "t5_tick_adv");
`endif

    rst = 1'b0; start = 1'b0; game_over = 1'b0; tick = 1'b0; kill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // mid-game reset at level 2
    pulse(1,0,0,0, 0,0,0,1, "t6_start");
    for (int i = 1; i <= 8; i++) begin
      pulse(0,0,1,0, i / 4, (i / 4) * 1000, (i % 4) == 0, 1'b1, "t6_tick");
    end
    rst = 1'b0; tick = 1'b1;
    @(posedge clk);
    #1;
    check_outs("t6_reset", 0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    pulse(0,0,1,0, 0,0,0,0, "t6_idle_tick");
    pulse(1,0,0,0, 0,0,0,1, "t6_restart");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/difficulty_ramp.md
# difficulty_ramp

Difficulty controller that produces the `dec[30:0]` period-decrement bus consumed by the timer cluster. It closes the loop on the pulses that the cluster emits: it counts elapsed-time ticks (and, optionally, kill events), advances a game level, and raises `dec` in saturating steps so that every timer period shortens as play continues. It sits between game control (start/over) and `timer_cluster`, on the fast clock domain.

## Interface
Parameters:
- `TICKS_PER_LEVEL`, default 10: tick pulses per level advance (≥1).
- `KILLS_PER_LEVEL`, default 5: kill pulses per level advance (≥1; used only with the macro).
- `DEC_STEP`, default 2_000_000: added to `dec` on each level advance.
- `DEC_MAX`, default 60_000_000: saturation ceiling of `dec`; must be below the smallest timer period.
- `MAX_LEVEL`, default 15: level ceiling.
- `LEVELW`, default 4: level output width; must hold `MAX_LEVEL`.

Ports:
- `clk` in 1: single clock (fast domain).
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse, begin or restart a game.
- `game_over` in 1: one-cycle pulse, freeze difficulty.
- `tick` in 1: one-cycle time pulse from a cluster timer.
- `kill` in 1: one-cycle enemy-destroyed pulse.
- `dec` out 31: decrement bus to the timer cluster.
- `level` out LEVELW: current level.
- `level_up` out 1: one-cycle pulse on each level advance.
- `running` out 1: high in RUN.

## Operation
- States: IDLE, RUN, FROZEN.
  - IDLE: after reset. On `start`, go to RUN and clear the counters, `level` and `dec`.
  - RUN: on `game_over`, go to FROZEN. `start` during RUN restarts: counters, `level` and `dec` are cleared and the state stays RUN.
  - FROZEN: holds `dec` and `level`. On `start`, clear everything and go to RUN.
- Priority: if `game_over` and `start` arrive in the same cycle, `game_over` wins. `tick` and `kill` are ignored outside RUN and in the cycle that `start` or `game_over` is taken.
- Tick counter:
  - Counts `tick` in RUN.
  - When it reaches `TICKS_PER_LEVEL`, it wraps to 0 and an advance is requested.
- Kill counter (macro builds only):
  - Same as the tick counter, with threshold `KILLS_PER_LEVEL`.
- Simultaneous requests: if both counters request in the same cycle, exactly one advance occurs and both counters wrap.
- Advance, when `level < MAX_LEVEL`:
  - `level` += 1.
  - `dec` = min(`dec` + `DEC_STEP`, `DEC_MAX`). The sum is computed 32 bits wide so it cannot wrap.
  - `level_up` pulses.
- Advance at `MAX_LEVEL`:
  - Counters still wrap.
  - `level` and `dec` are unchanged and `level_up` stays low.
- Invariant: `dec` never exceeds `DEC_MAX`.

## Timing
- Reset values: state IDLE, `dec` = 0, `level` = 0, `level_up` = 0, `running` = 0, counters 0.
- Reset asserted mid-game: all of the above on the next edge.
- All outputs are registered.
- Advance latency: `level`, `dec` and `level_up` change on the edge that samples the threshold-hitting `tick`/`kill`, so they are visible 1 cycle after the input pulse.
- `level_up` is high for exactly 1 cycle per advance.
- `running` goes high 1 cycle after `start` and low 1 cycle after `game_over`.
- Back-to-back `tick` pulses on consecutive cycles are each counted.

## Configuration
- `DIFFICULTY_KILL_BOOST_EN`:
  - Defined: the kill counter exists and kills also advance the level, as described above.
  - Undefined: the kill counter and its logic are not built, `kill` is ignored, and only ticks advance the level.
  - The port list is identical in both builds.

## Test plan
Common parameters: `TICKS_PER_LEVEL`=4, `KILLS_PER_LEVEL`=2, `DEC_STEP`=1000, `DEC_MAX`=2500, `MAX_LEVEL`=3.
1. Reset low for 2 cycles, then `start`, then 4 ticks: `level`=1, `dec`=1000, and one `level_up` 1 cycle after the 4th tick. 8 more ticks: `level`=3, `dec`=2500 (saturated from 3000).
2. At `level`=3, 4 more ticks: no `level_up`, `dec` stays 2500, `level` stays 3.
3. `start` 4 ticks + `game_over`, then 8 ticks: `level`=1, `dec`=1000 frozen, `running`=0. Next `start`: `level`=0, `dec`=0, `running`=1.
4. `start` and `game_over` in the same cycle while in RUN: goes to FROZEN and values are held. In IDLE, ticks are ignored and `dec` stays 0.
5. Macro defined: 3 ticks, then a cycle with `tick` and the 2nd `kill` together: exactly one `level_up`, `level`=1, both counters 0. Macro undefined: 10 kills leave `level`=0.
6. Reset driven low while at `level`=2: the next edge gives `dec`=0, `level`=0, state IDLE.
